// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and default sizing for the common-data-bus arbiter and its
// snooping consumers (reservation stations, register status table).
package cdb_arbiter_pkg;

  localparam int CDB_NUM_REQ = 4;
  localparam int CDB_TAG_W   = 5;
  localparam int CDB_DATA_W  = 32;

  // Tag 0 is reserved: it marks "no dependency" in qj/qk fields.
  localparam logic [CDB_TAG_W-1:0] CDB_TAG_NONE = '0;

  typedef logic [CDB_TAG_W-1:0] cdb_tag_t;

  typedef struct packed {
    logic                  valid;
    cdb_tag_t              tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundles the functional-unit result ports and the CDB broadcast. Functional
// units and control use the master view; the arbiter uses the slave view.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                      en;
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [SRC_W-1:0]          cdb_src;
  logic                      err_tag0;

  modport master (
    output en, flush, req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, err_tag0
  );

  modport slave (
    input  en, flush, req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, err_tag0
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin priority rotate: the first set request at or after
// the pointer (wrapping) wins. Kept generic for reuse on dispatch ports.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]                           i_req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0]   i_ptr,
  output logic [N-1:0]                           o_grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   o_idx,
  output logic                                   o_any
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] w_cand;

  // N is a power of two, so the IDX_W-bit add wraps modulo N for free.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = i_ptr + IDX_W'(i);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one FU result per cycle round-robin and
// broadcasts it registered as (tag, data, src) for exactly one cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input logic         clk,
  input logic         rst,
  cdb_arbiter_if.slave bus
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [SRC_W-1:0]   r_rrPtr;
  logic               r_cdbValid;
  logic [TAG_W-1:0]   r_cdbTag;
  logic [DATA_W-1:0]  r_cdbData;
  logic [SRC_W-1:0]   r_cdbSrc;
  logic               r_errTag0;

  logic [NUM_REQ-1:0] w_grant;
  logic [SRC_W-1:0]   w_grantIdx;
  logic               w_anyGrant;
  logic               w_gateOpen;
  logic               w_xfer;
  logic [TAG_W-1:0]   w_selTag;
  logic [DATA_W-1:0]  w_selData;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rrPtr),
    .o_grant (w_grant),
    .o_idx   (w_grantIdx),
    .o_any   (w_anyGrant)
  );

  // Reset outranks flush, which outranks enable; any of them suppresses grants.
  assign w_gateOpen    = !rst && bus.en && !bus.flush;
  assign w_xfer        = w_gateOpen && w_anyGrant;
  assign bus.req_ready = w_gateOpen ? w_grant : '0;

  assign w_selTag  = bus.req_tag[w_grantIdx*TAG_W +: TAG_W];
  assign w_selData = bus.req_data[w_grantIdx*DATA_W +: DATA_W];

  // A tag-0 result is consumed and advances the pointer but is never broadcast;
  // tag/data/src registers only move on a real broadcast.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrPtr    <= '0;
      r_cdbValid <= 1'b0;
      r_cdbTag   <= '0;
      r_cdbData  <= '0;
      r_cdbSrc   <= '0;
      r_errTag0  <= 1'b0;
    end else begin
      r_cdbValid <= 1'b0;
      if (w_xfer) begin
        r_rrPtr <= w_grantIdx + SRC_W'(1);
        if (w_selTag == '0) begin
          r_errTag0 <= 1'b1;
        end else begin
          r_cdbValid <= 1'b1;
          r_cdbTag   <= w_selTag;
          r_cdbData  <= w_selData;
          r_cdbSrc   <= w_grantIdx;
        end
      end
    end
  end

  assign bus.cdb_valid = r_cdbValid;
  assign bus.cdb_tag   = r_cdbTag;
  assign bus.cdb_data  = r_cdbData;
  assign bus.cdb_src   = r_cdbSrc;
  assign bus.err_tag0  = r_errTag0;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with NUM_REQ=4, TAG_W=5, DATA_W=32.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int TW = 5;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  cdb_arbiter_if #(.NUM_REQ(NR), .TAG_W(TW), .DATA_W(DW)) bus ();

  cdb_arbiter #(.NUM_REQ(NR), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1ns past the edge so outputs are settled.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NR-1:0] valid, input logic en, input logic flush);
    bus.req_valid = valid;
    bus.en        = en;
    bus.flush     = flush;
    #1;
  endtask

  task automatic setReq(input int idx, input logic [TW-1:0] tag, input logic [DW-1:0] data);
    bus.req_tag[idx*TW +: TW]  = tag;
    bus.req_data[idx*DW +: DW] = data;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
    end
  endtask

  task automatic checkCdb(input string name, input logic valid, input logic [TW-1:0] tag,
                          input logic [DW-1:0] data, input logic [1:0] src);
    checkOutput({name, ".valid"}, DW'(bus.cdb_valid), DW'(valid));
    checkOutput({name, ".tag"},   DW'(bus.cdb_tag),   DW'(tag));
    checkOutput({name, ".data"},  bus.cdb_data,       data);
    checkOutput({name, ".src"},   DW'(bus.cdb_src),   DW'(src));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    bus.req_tag  = '0;
    bus.req_data = '0;
    for (int i = 0; i < NR; i++) setReq(i, TW'(i + 1), 32'hA000_0000 + i);

    // Reset with every requester valid: no grant while rst is high.
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("rst_ready", DW'(bus.req_ready), 32'h0);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    #1;
    checkCdb("reset_state", 1'b0, 5'd0, 32'h0, 2'd0);
    checkOutput("reset_err", DW'(bus.err_tag0), 32'h0);

    // All four valid from reset: grants 0,1,2,3,0 and tags 1,2,3,4,1 with no bubbles.
    checkOutput("rr_ready0", DW'(bus.req_ready), 32'h1);
    stepCycle();
    checkCdb("rr_cdb0", 1'b1, 5'd1, 32'hA000_0000, 2'd0);
    checkOutput("rr_ready1", DW'(bus.req_ready), 32'h2);
    stepCycle();
    checkCdb("rr_cdb1", 1'b1, 5'd2, 32'hA000_0001, 2'd1);
    checkOutput("rr_ready2", DW'(bus.req_ready), 32'h4);
    stepCycle();
    checkCdb("rr_cdb2", 1'b1, 5'd3, 32'hA000_0002, 2'd2);
    checkOutput("rr_ready3", DW'(bus.req_ready), 32'h8);
    stepCycle();
    checkCdb("rr_cdb3", 1'b1, 5'd4, 32'hA000_0003, 2'd3);
    checkOutput("rr_ready4", DW'(bus.req_ready), 32'h1);
    stepCycle();
    checkCdb("rr_cdb4", 1'b1, 5'd1, 32'hA000_0000, 2'd0);

    // Reset mid-broadcast, then a single request from FU2 with tag 7.
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b1, 1'b0);
    stepCycle();
    rst = 1'b0;
    setReq(2, 5'd7, 32'hDEAD_BEEF);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    checkOutput("rstmid_valid", DW'(bus.cdb_valid), 32'h0);
    checkOutput("single_ready", DW'(bus.req_ready), 32'h4);
    stepCycle();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkCdb("single_cdb", 1'b1, 5'd7, 32'hDEAD_BEEF, 2'd2);
    stepCycle();
    checkCdb("idle_hold", 1'b0, 5'd7, 32'hDEAD_BEEF, 2'd2);

    // Pointer is now 3: with everyone valid, FU3 wins.
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("ptr3_ready", DW'(bus.req_ready), 32'h8);
    stepCycle();

    // Lone requester FU1 is granted on consecutive cycles; pointer ends at 2.
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("b2b_ready0", DW'(bus.req_ready), 32'h2);
    stepCycle();
    checkCdb("b2b_cdb0", 1'b1, 5'd2, 32'hA000_0001, 2'd1);
    checkOutput("b2b_ready1", DW'(bus.req_ready), 32'h2);
    stepCycle();
    checkCdb("b2b_cdb1", 1'b1, 5'd2, 32'hA000_0001, 2'd1);

    // FU1 and FU3 valid from pointer 2: FU3 first, FU1 waits with stable data.
    setReq(1, 5'd9, 32'h1111_1111);
    applyStimulus(4'b1010, 1'b1, 1'b0);
    checkOutput("wait_ready0", DW'(bus.req_ready), 32'h8);
    stepCycle();
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkCdb("wait_cdb3", 1'b1, 5'd4, 32'hA000_0003, 2'd3);
    checkOutput("wait_ready1", DW'(bus.req_ready), 32'h2);
    stepCycle();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkCdb("wait_cdb1", 1'b1, 5'd9, 32'h1111_1111, 2'd1);
    stepCycle();

    // Disabled for three cycles with all valid: nothing granted or broadcast.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0);
      checkOutput("dis_ready", DW'(bus.req_ready), 32'h0);
      checkOutput("dis_valid", DW'(bus.cdb_valid), 32'h0);
      stepCycle();
    end
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("dis_after_valid", DW'(bus.cdb_valid), 32'h0);
    checkOutput("resume_ready", DW'(bus.req_ready), 32'h4);
    stepCycle();

    // Flush in the cycle FU0 would win; the pending FU2 broadcast stays visible.
    applyStimulus(4'b0001, 1'b1, 1'b1);
    checkOutput("flush_ready", DW'(bus.req_ready), 32'h0);
    checkCdb("flush_cycle_cdb", 1'b1, 5'd7, 32'hDEAD_BEEF, 2'd2);
    stepCycle();
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("flush_next_valid", DW'(bus.cdb_valid), 32'h0);
    checkOutput("flush_next_ready", DW'(bus.req_ready), 32'h1);
    stepCycle();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkCdb("flush_after_cdb", 1'b1, 5'd1, 32'hA000_0000, 2'd0);
    stepCycle();

    // FU1 presents tag 0: consumed, not broadcast, sticky error raised.
    setReq(1, 5'd0, 32'h2222_2222);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("tag0_ready", DW'(bus.req_ready), 32'h2);
    stepCycle();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkCdb("tag0_cdb", 1'b0, 5'd1, 32'hA000_0000, 2'd0);
    checkOutput("tag0_err", DW'(bus.err_tag0), 32'h1);

    // Pointer advanced past FU1, so FU2 wins over FU1.
    setReq(1, 5'd2, 32'hA000_0001);
    applyStimulus(4'b0110, 1'b1, 1'b0);
    checkOutput("tag0_ptr_ready", DW'(bus.req_ready), 32'h4);
    stepCycle();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkCdb("tag0_next_cdb", 1'b1, 5'd7, 32'hDEAD_BEEF, 2'd2);
    checkOutput("tag0_err_sticky", DW'(bus.err_tag0), 32'h1);
    stepCycle();
    checkOutput("tag0_err_sticky2", DW'(bus.err_tag0), 32'h1);

    // Only reset clears the sticky error.
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    #1;
    checkOutput("err_cleared", DW'(bus.err_tag0), 32'h0);
    checkOutput("err_rst_valid", DW'(bus.cdb_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the common data bus (CDB) between functional-unit result ports.
- Each cycle, grants at most one valid requester using a round-robin pointer.
- The granted result is registered and broadcast for one cycle as (tag, data). Reservation stations and the register status table snoop this broadcast to clear qj/qk dependencies, which is what makes ops eligible for the schedule stage.

Parameters:
- NUM_REQ, 4, number of functional-unit result ports; power of two, 2..8.
- TAG_W, 5, result tag width (reservation-station index); tag 0 is reserved and means "no dependency".
- DATA_W, 32, result data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  stage enable; when low, no grants are issued
- flush  in  1  pipeline flush; kills the current grant and the pending broadcast
- req_valid  in  NUM_REQ  per-FU result valid
- req_ready  out  NUM_REQ  per-FU grant; one-hot or zero
- req_tag  in  NUM_REQ*TAG_W  per-FU result tag; packed, requester i at [i*TAG_W +: TAG_W]
- req_data  in  NUM_REQ*DATA_W  per-FU result data; packed likewise
- cdb_valid  out  1  broadcast valid, single-cycle pulse per transfer
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast data
- cdb_src  out  $clog2(NUM_REQ)  index of the requester that produced the broadcast
- err_tag0  out  1  sticky flag: a requester presented tag 0

Behaviour:
- Reset values: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, err_tag0=0, rr_ptr=0.
- Grant rule (combinational):
  - Search req_valid starting at rr_ptr, ascending with wrap modulo NUM_REQ.
  - The first valid index g gets req_ready[g]=1; every other ready bit is 0.
  - req_ready is all-zero when rst, !en, flush, or no valid request exists.
- Transfer and handshake:
  - A transfer occurs when req_valid[g] && req_ready[g].
  - The FU must hold valid, tag and data stable until it is granted.
  - The arbiter never drops a valid request unless flush is asserted.
- Latency: a transfer in cycle N produces cdb_valid=1 in cycle N+1, with cdb_tag/cdb_data/cdb_src captured from requester g.
- Throughput: one result per cycle.
- No-transfer cycles: cdb_valid <= 0. cdb_tag, cdb_data and cdb_src hold their last values; consumers must qualify with cdb_valid.
- Pointer update: on a transfer, rr_ptr <= (g+1) mod NUM_REQ; otherwise rr_ptr holds.
  - Consequence: with continuously valid requesters, each is served at least once every NUM_REQ cycles (no starvation).
- Tag 0 handling:
  - If the granted request has tag 0, it is still consumed (ready=1) and rr_ptr still advances.
  - cdb_valid <= 0 for that transfer, and err_tag0 <= 1.
  - err_tag0 clears only on rst.
- Flush:
  - Takes effect in the cycle it is asserted: no grant, cdb_valid <= 0 next cycle, rr_ptr held.
  - A broadcast already registered (cdb_valid=1 in the flush cycle) is still visible for that cycle.
- Disable: en low gives no grant and cdb_valid <= 0 next cycle; rr_ptr and err_tag0 hold.
- Precedence when events coincide: rst > flush > en.
- Reset mid-broadcast: cdb_valid is 0 in the cycle after rst is sampled, regardless of requests.
- Single requester: with only req_valid[i] high, it is granted every cycle, giving back-to-back broadcasts.

Decomposition:
- qu_common additions:
  - cdb_tag_t (TAG_W, aligned with res_st_addr_t)
  - cdb_bus_t struct {valid, tag, data}
  - localparam CDB_NUM_REQ
- Sub-module rr_arbiter:
  - Inputs: req vector and ptr. Outputs: one-hot grant, encoded index, any-grant.
  - Purely combinational priority rotate.
  - Reusable later for dispatch-port arbitration.
- cdb_arbiter keeps rr_ptr, the output register, the tag-0 check and flush/en gating.

Test Plan:
- Reset, then req_valid[2]=1 with tag=7, data=0xDEAD_BEEF: req_ready=0100 in cycle N; cycle N+1 gives cdb_valid=1, tag=7, data=0xDEADBEEF, src=2; rr_ptr=3.
- All four valid continuously from reset, tags 1..4: grants in order 0,1,2,3,0; cdb_tag sequence 1,2,3,4,1 on consecutive cycles with no bubbles.
- Requesters 1 and 3 valid with rr_ptr=2: grant 3 first, then 1. Requester 1 keeps valid/data stable while waiting, and its data appears unchanged on the CDB.
- en=0 for 3 cycles with all four valid: req_ready=0000 and cdb_valid=0 throughout. After en=1, the grant resumes at the held rr_ptr.
- flush in the cycle requester 0 would be granted: req_ready=0000, cdb_valid=0 next cycle, rr_ptr unchanged. Next cycle requester 0 is granted.
- Requester 1 presents tag 0: it is consumed, cdb_valid stays 0 and err_tag0 rises and stays high. Only rst clears err_tag0 back to 0.
